// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback steps, and drives every mux select and write enable in it.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EN_BNE        = 1'b1,
    parameter bit EN_JUMP       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       ULAsrcA,
    output logic [1:0] ULAsrcB,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] ULAcontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q;
    state_e state_d;
    logic   memReady;
    logic   pcWrite;
    logic   branch;
    logic   isBne;
    logic   functLegal;
    logic [2:0] aluFunct;

    assign memReady = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign isBne    = (op == OP_BNE);
    assign state    = state_q;

    always_comb begin
        functLegal = 1'b1;
        aluFunct   = 3'b010;
        case (funct)
            6'b100000: aluFunct = 3'b010;
            6'b100010: aluFunct = 3'b110;
            6'b100100: aluFunct = 3'b000;
            6'b100101: aluFunct = 3'b001;
            6'b101010: aluFunct = 3'b111;
            default:   functLegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        ULAsrcA    = 1'b0;
        ULAsrcB    = 2'b00;
        pcsrc      = 2'b00;
        ULAcontrol = 3'b000;
        illegal_op = 1'b0;
        pcWrite    = 1'b0;
        branch     = 1'b0;
        pcen       = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread    = 1'b1;
                ULAsrcB    = 2'b01;
                ULAcontrol = 3'b010;
                if (memReady) begin
                    irwrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ULAsrcB    = 2'b11;
                ULAcontrol = 3'b010;
                state_d    = S_FETCH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (functLegal) state_d = S_EXECUTE;
                        else            illegal_op = 1'b1;
                    end
                    OP_BEQ: state_d = S_BRANCH;
                    OP_BNE: begin
                        if (EN_BNE) state_d = S_BRANCH;
                        else        illegal_op = 1'b1;
                    end
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J: begin
                        if (EN_JUMP) state_d = S_JUMP;
                        else         illegal_op = 1'b1;
                    end
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ULAsrcA    = 1'b1;
                ULAsrcB    = 2'b10;
                ULAcontrol = 3'b010;
                state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (memReady) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ULAsrcA    = 1'b1;
                ULAcontrol = aluFunct;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ULAsrcA    = 1'b1;
                ULAcontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ULAsrcA    = 1'b1;
                ULAsrcB    = 2'b10;
                ULAcontrol = 3'b010;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        pcen = pcWrite | (branch & (zero ^ isBne));

        // Reset suppresses every strobe at once, so an aborted store never completes
        if (reset) begin
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

endmodule
